// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the RV32IM 5-stage pipeline: operand forwarding, load-use and
// long-op (DIV/REM) hazard detection, branch flush, stall perf counters.

module hsu_fwd_sel #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_E,
    input  logic [REG_AW-1:0] rd_M,
    input  logic              reg_write_M,
    input  logic [REG_AW-1:0] rd_W,
    input  logic              reg_write_W,
    output logic [1:0]        fwd
);
    always_comb begin
        fwd = 2'b00;
        if (reg_write_M && rd_M != '0 && rd_M == rs_E)
            fwd = 2'b10;
        else if (reg_write_W && rd_W != '0 && rd_W == rs_E)
            fwd = 2'b01;
    end
endmodule

module hazard_scoreboard_unit #(
    parameter int REG_AW      = 5,
    parameter int MAX_PENDING = 2,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1_D,
    input  logic [REG_AW-1:0] rs2_D,
    input  logic              rs1_used_D,
    input  logic              rs2_used_D,
    input  logic [REG_AW-1:0] rd_D,
    input  logic              reg_write_D,
    input  logic              long_op_D,
    input  logic [REG_AW-1:0] rs1_E,
    input  logic [REG_AW-1:0] rs2_E,
    input  logic [REG_AW-1:0] rd_E,
    input  logic              reg_write_E,
    input  logic              mem_read_E,
    input  logic              long_start_E,
    input  logic              branch_taken_E,
    input  logic [REG_AW-1:0] rd_M,
    input  logic              reg_write_M,
    input  logic [REG_AW-1:0] rd_W,
    input  logic              reg_write_W,
    input  logic              long_done,
    input  logic              cnt_clr,
    output logic [1:0]        forward_a_E,
    output logic [1:0]        forward_b_E,
    output logic              stall_F,
    output logic              stall_D,
    output logic              flush_D,
    output logic              flush_E,
    output logic [CNT_W-1:0]  lu_stall_cnt,
    output logic [CNT_W-1:0]  lo_stall_cnt,
    output logic              err_overflow,
    output logic              err_underflow
);
    localparam int CW = $clog2(MAX_PENDING + 1);

    // ---------------- forwarding, one selector per EX operand
    logic [1:0][REG_AW-1:0] rs_E;
    logic [1:0][1:0]        fwd;

    assign rs_E = {rs2_E, rs1_E};

    for (genvar g = 0; g < 2; g++) begin : g_fwd
        hsu_fwd_sel #(.REG_AW(REG_AW)) u_fwd (
            .rs_E        (rs_E[g]),
            .rd_M        (rd_M),
            .reg_write_M (reg_write_M),
            .rd_W        (rd_W),
            .reg_write_W (reg_write_W),
            .fwd         (fwd[g])
        );
    end

    // ---------------- scoreboard FIFO, entry 0 is the oldest
    logic [MAX_PENDING-1:0]             sb_vld, sb_vld_nxt;
    logic [MAX_PENDING-1:0][REG_AW-1:0] sb_rd, sb_rd_nxt;
    logic [CW-1:0]                      sb_cnt, sb_cnt_nxt, push_idx;
    logic                               sb_full, sb_empty, push, pop;

    assign sb_empty = (sb_cnt == '0);
    assign sb_full  = (sb_cnt == CW'(MAX_PENDING));
    assign pop      = long_done && !sb_empty;
    // A full FIFO can still take a push if the oldest entry leaves this cycle.
    assign push     = long_start_E && (!sb_full || pop);
    assign push_idx = sb_cnt - CW'(pop);

    always_comb begin
        sb_vld_nxt = sb_vld;
        sb_rd_nxt  = sb_rd;
        sb_cnt_nxt = sb_cnt;
        if (pop) begin
            for (int i = 0; i < MAX_PENDING - 1; i++) begin
                sb_vld_nxt[i] = sb_vld[i+1];
                sb_rd_nxt[i]  = sb_rd[i+1];
            end
            sb_vld_nxt[MAX_PENDING-1] = 1'b0;
            sb_rd_nxt[MAX_PENDING-1]  = '0;
        end
        if (push) begin
            for (int i = 0; i < MAX_PENDING; i++) begin
                if (CW'(i) == push_idx) begin
                    sb_vld_nxt[i] = 1'b1;
                    sb_rd_nxt[i]  = rd_E;
                end
            end
        end
        sb_cnt_nxt = sb_cnt + CW'(push) - CW'(pop);
    end

    // ---------------- hazard detection
    logic          lu, lo, lo_dep, lo_struct;
    logic [CW:0]   occ;

    assign lu = mem_read_E && rd_E != '0 &&
                ((rs1_used_D && rs1_D == rd_E) || (rs2_used_D && rs2_D == rd_E));

    // RAW/WAW against live entries; the one retiring now is covered by WB forwarding.
    always_comb begin
        lo_dep = 1'b0;
        for (int i = 0; i < MAX_PENDING; i++) begin
            if (sb_vld[i] && !(pop && i == 0) && sb_rd[i] != '0 &&
                ((rs1_used_D && rs1_D == sb_rd[i]) ||
                 (rs2_used_D && rs2_D == sb_rd[i]) ||
                 (reg_write_D && rd_D == sb_rd[i])))
                lo_dep = 1'b1;
        end
        if (long_start_E && rd_E != '0 &&
            ((rs1_used_D && rs1_D == rd_E) ||
             (rs2_used_D && rs2_D == rd_E) ||
             (reg_write_D && rd_D == rd_E)))
            lo_dep = 1'b1;
    end

    assign occ       = {1'b0, sb_cnt} + (CW+1)'(long_start_E);
    assign lo_struct = long_op_D && (occ >= (CW+1)'(MAX_PENDING));
    assign lo        = lo_dep || lo_struct;

    // ---------------- pipeline control, forced idle while in reset
    always_comb begin
        forward_a_E = 2'b00;
        forward_b_E = 2'b00;
        stall_F     = 1'b0;
        stall_D     = 1'b0;
        flush_D     = 1'b0;
        flush_E     = 1'b0;
        if (rst_n) begin
            forward_a_E = fwd[0];
            forward_b_E = fwd[1];
            if (branch_taken_E) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
            end else if (lu || lo) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
        end
    end

    // ---------------- state: scoreboard, counters, sticky errors
    logic lu_inc, lo_inc;

    assign lu_inc = lu && !branch_taken_E;
    assign lo_inc = lo && !lu && !branch_taken_E;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb_vld        <= '0;
            sb_rd         <= '0;
            sb_cnt        <= '0;
            lu_stall_cnt  <= '0;
            lo_stall_cnt  <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            sb_vld <= sb_vld_nxt;
            sb_rd  <= sb_rd_nxt;
            sb_cnt <= sb_cnt_nxt;
            if (cnt_clr) begin
                lu_stall_cnt <= '0;
                lo_stall_cnt <= '0;
            end else begin
                if (lu_inc && lu_stall_cnt != '1) lu_stall_cnt <= lu_stall_cnt + 1'b1;
                if (lo_inc && lo_stall_cnt != '1) lo_stall_cnt <= lo_stall_cnt + 1'b1;
            end
            if (long_start_E && sb_full && !pop) err_overflow  <= 1'b1;
            if (long_done && sb_empty)           err_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench: each cycle's stimulus queues its expected outputs; a negedge
// monitor pops and compares them against the DUT.

module tb_hazard_scoreboard_unit;
    localparam int RA = 5;
    localparam int MP = 2;
    localparam int CW = 6;

    localparam logic [3:0] NO = 4'b0000;  // {stall_F, stall_D, flush_D, flush_E}
    localparam logic [3:0] ST = 4'b1101;
    localparam logic [3:0] BR = 4'b0011;

    logic clk, rst_n;
    logic [RA-1:0] rs1_D, rs2_D, rd_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic rs1_used_D, rs2_used_D, reg_write_D, long_op_D;
    logic reg_write_E, mem_read_E, long_start_E, branch_taken_E;
    logic reg_write_M, reg_write_W, long_done, cnt_clr;
    logic [1:0] forward_a_E, forward_b_E;
    logic stall_F, stall_D, flush_D, flush_E, err_overflow, err_underflow;
    logic [CW-1:0] lu_stall_cnt, lo_stall_cnt;

    hazard_scoreboard_unit #(.REG_AW(RA), .MAX_PENDING(MP), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_used_D(rs1_used_D), .rs2_used_D(rs2_used_D),
        .rd_D(rd_D), .reg_write_D(reg_write_D), .long_op_D(long_op_D),
        .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
        .reg_write_E(reg_write_E), .mem_read_E(mem_read_E),
        .long_start_E(long_start_E), .branch_taken_E(branch_taken_E),
        .rd_M(rd_M), .reg_write_M(reg_write_M), .rd_W(rd_W), .reg_write_W(reg_write_W),
        .long_done(long_done), .cnt_clr(cnt_clr),
        .forward_a_E(forward_a_E), .forward_b_E(forward_b_E),
        .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
        .lu_stall_cnt(lu_stall_cnt), .lo_stall_cnt(lo_stall_cnt),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [21:0] v;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    function automatic string fmt(input logic [21:0] v);
        return $sformatf("fa=%b fb=%b ctl=%b lu=%0d lo=%0d ovf=%b unf=%b",
                         v[21:20], v[19:18], v[17:14], v[13:8], v[7:2], v[1], v[0]);
    endfunction

    // Monitor: compares the oldest queued expectation every falling edge.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [21:0] act;
            e   = q.pop_front();
            act = {forward_a_E, forward_b_E, stall_F, stall_D, flush_D, flush_E,
                   lu_stall_cnt, lo_stall_cnt, err_overflow, err_underflow};
            n_chk++;
            if (act === e.v) n_pass++;
            else $display("FAIL %s: got %s, want %s", e.name, fmt(act), fmt(e.v));
        end
    end

    task automatic idle();
        rst_n = 1'b1;
        rs1_D = '0; rs2_D = '0; rd_D = '0; rs1_E = '0; rs2_E = '0; rd_E = '0;
        rd_M = '0; rd_W = '0;
        rs1_used_D = 0; rs2_used_D = 0; reg_write_D = 0; long_op_D = 0;
        reg_write_E = 0; mem_read_E = 0; long_start_E = 0; branch_taken_E = 0;
        reg_write_M = 0; reg_write_W = 0; long_done = 0; cnt_clr = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_out(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                              input logic [3:0] ctl, input int lu, input int lo,
                              input logic ov, input logic un);
        exp_t e;
        e.name = nm;
        e.v    = {fa, fb, ctl, CW'(lu), CW'(lo), ov, un};
        q.push_back(e);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;

        // reset: outputs forced idle even with hazard-looking inputs
        cyc(); rst_n = 0; reg_write_M = 1; rd_M = 5; rs1_E = 5; rs2_E = 5;
        mem_read_E = 1; rd_E = 7; rs1_D = 7; rs1_used_D = 1; branch_taken_E = 1;
        expect_out("reset", 2'b00, 2'b00, NO, 0, 0, 0, 0);

        // forwarding
        cyc(); reg_write_M = 1; rd_M = 5; reg_write_W = 1; rd_W = 5; rs1_E = 5; rs2_E = 5;
        expect_out("fwd_mem_prio", 2'b10, 2'b10, NO, 0, 0, 0, 0);
        cyc(); reg_write_M = 1; rd_M = 0; reg_write_W = 1; rd_W = 5; rs1_E = 5; rs2_E = 5;
        expect_out("fwd_wb", 2'b01, 2'b01, NO, 0, 0, 0, 0);
        cyc(); reg_write_M = 1; rd_M = 5; reg_write_W = 1; rd_W = 6; rs1_E = 5; rs2_E = 6;
        expect_out("fwd_mixed", 2'b10, 2'b01, NO, 0, 0, 0, 0);
        cyc(); reg_write_M = 1; reg_write_W = 1;
        expect_out("fwd_x0", 2'b00, 2'b00, NO, 0, 0, 0, 0);
        cyc(); rd_M = 5; rd_W = 5; rs1_E = 5; rs2_E = 5;
        expect_out("fwd_no_we", 2'b00, 2'b00, NO, 0, 0, 0, 0);

        // load-use
        cyc(); mem_read_E = 1; rd_E = 7; rs2_D = 7; rs2_used_D = 1;
        expect_out("lu_stall", 2'b00, 2'b00, ST, 0, 0, 0, 0);
        cyc(); rs2_D = 7; rs2_used_D = 1; reg_write_M = 1; rd_M = 7;
        expect_out("lu_released", 2'b00, 2'b00, NO, 1, 0, 0, 0);
        cyc(); mem_read_E = 1; rd_E = 7; rs1_D = 7; rs2_D = 7;
        expect_out("lu_unused_src", 2'b00, 2'b00, NO, 1, 0, 0, 0);
        cyc(); mem_read_E = 1; rd_E = 0; rs1_D = 0; rs1_used_D = 1;
        expect_out("lu_x0", 2'b00, 2'b00, NO, 1, 0, 0, 0);
        cyc(); reg_write_E = 1; rd_E = 7; rs1_D = 7; rs1_used_D = 1;
        expect_out("lu_not_load", 2'b00, 2'b00, NO, 1, 0, 0, 0);

        // DIV x9 with dependent consumer: 34 stall cycles
        cyc(); long_start_E = 1; reg_write_E = 1; rd_E = 9; rs1_D = 9; rs1_used_D = 1;
        expect_out("div_stall0", 2'b00, 2'b00, ST, 1, 0, 0, 0);
        for (int i = 1; i < 34; i++) begin
            cyc(); rs1_D = 9; rs1_used_D = 1;
            expect_out($sformatf("div_stall%0d", i), 2'b00, 2'b00, ST, 1, i, 0, 0);
        end
        cyc(); long_done = 1; rs1_D = 9; rs1_used_D = 1;
        expect_out("div_done", 2'b00, 2'b00, NO, 1, 34, 0, 0);
        cyc(); rs1_D = 9; rs1_used_D = 1;
        expect_out("div_after", 2'b00, 2'b00, NO, 1, 34, 0, 0);

        // structural: MAX_PENDING=2
        cyc(); long_start_E = 1; rd_E = 10; long_op_D = 1; rd_D = 12; reg_write_D = 1;
        expect_out("struct_ok", 2'b00, 2'b00, NO, 1, 34, 0, 0);
        cyc(); long_start_E = 1; rd_E = 11; long_op_D = 1; rd_D = 13; reg_write_D = 1;
        expect_out("struct_push_full", 2'b00, 2'b00, ST, 1, 34, 0, 0);
        cyc(); long_op_D = 1; rd_D = 13; reg_write_D = 1;
        expect_out("struct_full", 2'b00, 2'b00, ST, 1, 35, 0, 0);
        cyc(); long_done = 1; long_op_D = 1; rd_D = 13; reg_write_D = 1;
        expect_out("struct_pop_same", 2'b00, 2'b00, ST, 1, 36, 0, 0);
        cyc(); long_op_D = 1; rd_D = 13; reg_write_D = 1; rs1_D = 10; rs1_used_D = 1;
        expect_out("struct_issue", 2'b00, 2'b00, NO, 1, 37, 0, 0);

        // FIFO order: [11] then push 13
        cyc(); long_start_E = 1; rd_E = 13; rs1_D = 11; rs1_used_D = 1;
        expect_out("order_raw11", 2'b00, 2'b00, ST, 1, 37, 0, 0);
        cyc(); long_done = 1; rs1_D = 11; rs1_used_D = 1;
        expect_out("order_pop11", 2'b00, 2'b00, NO, 1, 38, 0, 0);
        cyc(); rd_D = 13; reg_write_D = 1;
        expect_out("order_waw13", 2'b00, 2'b00, ST, 1, 38, 0, 0);
        cyc(); long_done = 1; rd_D = 13; reg_write_D = 1;
        expect_out("order_pop13", 2'b00, 2'b00, NO, 1, 39, 0, 0);

        // branch overrides stalls
        cyc(); long_start_E = 1; rd_E = 14; rs1_D = 14; rs1_used_D = 1; branch_taken_E = 1;
        expect_out("br_over_lo", 2'b00, 2'b00, BR, 1, 39, 0, 0);
        cyc(); mem_read_E = 1; rd_E = 7; rs1_D = 7; rs1_used_D = 1;
        rs2_D = 14; rs2_used_D = 1; branch_taken_E = 1;
        expect_out("br_over_lu", 2'b00, 2'b00, BR, 1, 39, 0, 0);
        cyc(); mem_read_E = 1; rd_E = 7; rs1_D = 7; rs1_used_D = 1; rs2_D = 14; rs2_used_D = 1;
        expect_out("lu_and_lo", 2'b00, 2'b00, ST, 1, 39, 0, 0);
        cyc(); long_done = 1;
        expect_out("lu_only_counted", 2'b00, 2'b00, NO, 2, 39, 0, 0);

        // underflow
        cyc(); long_done = 1;
        expect_out("unf_cycle", 2'b00, 2'b00, NO, 2, 39, 0, 0);
        cyc();
        expect_out("unf_set", 2'b00, 2'b00, NO, 2, 39, 0, 1);
        cyc();
        expect_out("unf_sticky", 2'b00, 2'b00, NO, 2, 39, 0, 1);

        // overflow: third push dropped
        cyc(); long_start_E = 1; rd_E = 1;
        expect_out("ovf_push1", 2'b00, 2'b00, NO, 2, 39, 0, 1);
        cyc(); long_start_E = 1; rd_E = 2;
        expect_out("ovf_push2", 2'b00, 2'b00, NO, 2, 39, 0, 1);
        cyc(); long_start_E = 1; rd_E = 3;
        expect_out("ovf_push3", 2'b00, 2'b00, NO, 2, 39, 0, 1);
        cyc(); rs1_D = 3; rs1_used_D = 1;
        expect_out("ovf_dropped", 2'b00, 2'b00, NO, 2, 39, 1, 1);
        cyc(); rs1_D = 2; rs1_used_D = 1;
        expect_out("ovf_kept2", 2'b00, 2'b00, ST, 2, 39, 1, 1);
        cyc(); long_done = 1; rs1_D = 2; rs1_used_D = 1;
        expect_out("ovf_pop1", 2'b00, 2'b00, ST, 2, 40, 1, 1);
        cyc(); long_done = 1; rs1_D = 2; rs1_used_D = 1;
        expect_out("ovf_pop2", 2'b00, 2'b00, NO, 2, 41, 1, 1);

        // clear beats increment
        cyc(); cnt_clr = 1; mem_read_E = 1; rd_E = 7; rs1_D = 7; rs1_used_D = 1;
        expect_out("clr_cycle", 2'b00, 2'b00, ST, 2, 41, 1, 1);
        cyc();
        expect_out("clr_done", 2'b00, 2'b00, NO, 0, 0, 1, 1);

        // saturation of lo counter at 63
        cyc(); long_start_E = 1; rd_E = 20; rs1_D = 20; rs1_used_D = 1;
        expect_out("sat0", 2'b00, 2'b00, ST, 0, 0, 1, 1);
        for (int i = 1; i < 70; i++) begin
            cyc(); rs1_D = 20; rs1_used_D = 1;
            expect_out($sformatf("sat%0d", i), 2'b00, 2'b00, ST, 0, (i > 63) ? 63 : i, 1, 1);
        end
        cyc(); long_done = 1; rs1_D = 20; rs1_used_D = 1;
        expect_out("sat_done", 2'b00, 2'b00, NO, 0, 63, 1, 1);

        // reset mid-operation discards pending entry
        cyc(); long_start_E = 1; rd_E = 21;
        expect_out("rst_push21", 2'b00, 2'b00, NO, 0, 63, 1, 1);
        cyc(); rst_n = 0; reg_write_M = 1; rd_M = 5; rs1_E = 5;
        mem_read_E = 1; rd_E = 7; rs2_D = 7; rs2_used_D = 1; branch_taken_E = 1;
        expect_out("rst_forced", 2'b00, 2'b00, NO, 0, 63, 1, 1);
        cyc(); rs1_D = 21; rs1_used_D = 1; long_op_D = 1;
        expect_out("rst_cleared", 2'b00, 2'b00, NO, 0, 0, 0, 0);
        cyc(); reg_write_M = 1; rd_M = 5; rs1_E = 5;
        expect_out("rst_resume", 2'b10, 2'b00, NO, 0, 0, 0, 0);

        cyc();
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
